// File: rtl/sort_job_arbiter.sv
// sort_job_arbiter: round-robin front end that shares a single sorter between
// NUM_REQ requesters. It grants one requester, captures that requester's
// array, runs the sorter under a watchdog, and returns the result tagged with
// the requester index over a valid/ready response channel.
// Optional feature macro: SORT_ARB_PERF_EN (RUN-cycle counter on o_perf_cycles).
module sort_job_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int NUM_VALS    = 8,
  parameter int SIZE_DATA   = 8,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                                           i_clk,
  input  logic                                           i_rst_n,
  input  logic [NUM_REQ-1:0]                             i_req_valid,
  input  logic [NUM_REQ*NUM_VALS*SIZE_DATA-1:0]          i_req_data,
  output logic [NUM_REQ-1:0]                             o_req_ready,
  output logic                                           o_sort_start,
  output logic [NUM_VALS*SIZE_DATA-1:0]                  o_sort_data,
  input  logic                                           i_sort_done,
  input  logic [NUM_VALS*SIZE_DATA-1:0]                  i_sort_data,
  output logic                                           o_rsp_valid,
  input  logic                                           i_rsp_ready,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] o_rsp_id,
  output logic [NUM_VALS*SIZE_DATA-1:0]                  o_rsp_data,
  output logic                                           o_rsp_timeout,
  output logic                                           o_busy,
  output logic [15:0]                                    o_perf_cycles
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int AW  = NUM_VALS * SIZE_DATA;
  localparam int WDW = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [AW-1:0]  buffer;
  logic [WDW-1:0] wd_cnt;
  logic           wd_hit;

  logic [AW-1:0]  req_slice [NUM_REQ];
  logic           found_any;
  logic           found_hi;
  logic [IDW-1:0] lowest_any;
  logic [IDW-1:0] lowest_hi;
  logic [IDW-1:0] grant_idx;
  logic [IDW-1:0] next_ptr;

  // Unpack the flattened request bus into one array per requester
  always_comb begin
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      req_slice[r] = i_req_data[r*AW +: AW];
    end
  end

  // Round-robin pick: lowest requester at or above the pointer, else lowest overall (wrap)
  always_comb begin
    found_any  = 1'b0;
    found_hi   = 1'b0;
    lowest_any = '0;
    lowest_hi  = '0;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      if (i_req_valid[r] && !found_any) begin
        found_any  = 1'b1;
        lowest_any = IDW'(r);
      end
      if (i_req_valid[r] && (IDW'(r) >= rr_ptr) && !found_hi) begin
        found_hi  = 1'b1;
        lowest_hi = IDW'(r);
      end
    end
    grant_idx = found_hi ? lowest_hi : lowest_any;
    next_ptr  = (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
  end

  // Acceptance pulse is only offered while idle, in the grant cycle itself
  always_comb begin
    o_req_ready = '0;
    if ((state == IDLE) && found_any) begin
      o_req_ready[grant_idx] = 1'b1;
    end
  end

  assign wd_hit      = (wd_cnt == WDW'(TIMEOUT_CYC - 1));
  assign o_sort_data = buffer;
  assign o_busy      = (state != IDLE);

  // Job sequencer: grant/capture, start sorter, watchdog, hold response until accepted
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      buffer        <= '0;
      wd_cnt        <= '0;
      o_sort_start  <= 1'b0;
      o_rsp_valid   <= 1'b0;
      o_rsp_id      <= '0;
      o_rsp_data    <= '0;
      o_rsp_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found_any) begin
            buffer       <= req_slice[grant_idx];
            o_rsp_id     <= grant_idx;
            rr_ptr       <= next_ptr;
            o_sort_start <= 1'b1;
            state        <= LOAD;
          end
        end
        LOAD: begin
          wd_cnt <= '0;
          state  <= RUN;
        end
        RUN: begin
          // done is tested first so it wins over a simultaneous watchdog expiry
          if (i_sort_done) begin
            o_rsp_data    <= i_sort_data;
            o_rsp_timeout <= 1'b0;
            o_sort_start  <= 1'b0;
            o_rsp_valid   <= 1'b1;
            state         <= RESP;
          end else if (wd_hit) begin
            o_rsp_data    <= buffer;
            o_rsp_timeout <= 1'b1;
            o_sort_start  <= 1'b0;
            o_rsp_valid   <= 1'b1;
            state         <= RESP;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        RESP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SORT_ARB_PERF_EN
  logic [15:0] perf_q;
  logic [31:0] run_cycles;

  assign run_cycles    = 32'(wd_cnt) + 32'd1;
  assign o_perf_cycles = perf_q;

  // Record the RUN length of each job as it leaves RUN, saturating at 16 bits
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      perf_q <= '0;
    end else if ((state == RUN) && (i_sort_done || wd_hit)) begin
      perf_q <= (run_cycles > 32'd65535) ? 16'hFFFF : run_cycles[15:0];
    end
  end
`else
  assign o_perf_cycles = '0;
`endif

endmodule

// File: tb/tb_sort_job_arbiter.sv
// Bench for sort_job_arbiter: directed sections plus randomized jobs, checked
// against a queue-based reference (round-robin pick by search, sort by queue).
module tb_sort_job_arbiter;

  localparam int NR  = 4;
  localparam int NV  = 8;
  localparam int SD  = 8;
  localparam int TO  = 48;
  localparam int AW  = NV * SD;
  localparam int IDW = 2;

  logic                 i_clk = 1'b0;
  logic                 i_rst_n = 1'b0;
  logic [NR-1:0]        i_req_valid = '0;
  logic [NR*AW-1:0]     i_req_data = '0;
  logic [NR-1:0]        o_req_ready;
  logic                 o_sort_start;
  logic [AW-1:0]        o_sort_data;
  logic                 i_sort_done = 1'b0;
  logic [AW-1:0]        i_sort_data = '0;
  logic                 o_rsp_valid;
  logic                 i_rsp_ready = 1'b0;
  logic [IDW-1:0]       o_rsp_id;
  logic [AW-1:0]        o_rsp_data;
  logic                 o_rsp_timeout;
  logic                 o_busy;
  logic [15:0]          o_perf_cycles;

  int vectors = 0;
  int miscompares = 0;
  int ptr_m = 0;
  int perf_m = 0;

  sort_job_arbiter #(
    .NUM_REQ(NR),
    .NUM_VALS(NV),
    .SIZE_DATA(SD),
    .TIMEOUT_CYC(TO)
  ) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid),
    .i_req_data(i_req_data),
    .o_req_ready(o_req_ready),
    .o_sort_start(o_sort_start),
    .o_sort_data(o_sort_data),
    .i_sort_done(i_sort_done),
    .i_sort_data(i_sort_data),
    .o_rsp_valid(o_rsp_valid),
    .i_rsp_ready(i_rsp_ready),
    .o_rsp_id(o_rsp_id),
    .o_rsp_data(o_rsp_data),
    .o_rsp_timeout(o_rsp_timeout),
    .o_busy(o_busy),
    .o_perf_cycles(o_perf_cycles)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] rand_arr();
    logic [AW-1:0] r;
    for (int e = 0; e < NV; e++) r[e*SD +: SD] = SD'($urandom);
    return r;
  endfunction

  // Reference sort: ascending, element 0 smallest
  function automatic logic [AW-1:0] sort_arr(input logic [AW-1:0] a);
    logic [SD-1:0] q[$];
    logic [AW-1:0] r;
    for (int e = 0; e < NV; e++) q.push_back(a[e*SD +: SD]);
    q.sort();
    for (int e = 0; e < NV; e++) r[e*SD +: SD] = q[e];
    return r;
  endfunction

  // Reference grant: first requester found scanning upward from the pointer with wrap
  function automatic int model_grant(input logic [NR-1:0] mask);
    for (int i = 0; i < NR; i++) begin
      if (mask[(ptr_m + i) % NR]) return (ptr_m + i) % NR;
    end
    return -1;
  endfunction

  // One complete job, called at posedge+1 while the DUT is idle.
  // done_at: RUN cycle on which the sorter raises done (0 = never).
  // hold: cycles of back-pressure before the response is accepted.
  task automatic run_job(input logic [NR-1:0] mask, input int done_at, input int hold);
    int g;
    int ex;
    bit to;
    logic [AW-1:0] cap;
    logic [AW-1:0] res;
    i_req_valid = mask;
    @(negedge i_clk);
    chk("idle_busy", AW'(o_busy), '0);
    chk("idle_rsp_valid", AW'(o_rsp_valid), '0);
    g = model_grant(mask);
    cap = i_req_data[g*AW +: AW];
    chk("grant_ready", AW'(o_req_ready), AW'(1) << g);
    ptr_m = (g + 1) % NR;
    @(posedge i_clk); #1;
    i_req_data[g*AW +: AW] = rand_arr();
    @(negedge i_clk);
    chk("load_ready_pulse", AW'(o_req_ready), '0);
    chk("load_start", AW'(o_sort_start), AW'(1));
    chk("load_sort_data", o_sort_data, cap);
    chk("load_busy", AW'(o_busy), AW'(1));
    to = !(done_at >= 1 && done_at <= TO);
    ex = to ? TO : done_at;
    res = to ? cap : sort_arr(cap);
    for (int c = 1; c <= ex; c++) begin
      @(posedge i_clk); #1;
      i_sort_done = (c == done_at);
      i_sort_data = (c == done_at) ? sort_arr(cap) : rand_arr();
      @(negedge i_clk);
      if (c == 1 || c == ex) begin
        chk("run_start", AW'(o_sort_start), AW'(1));
        chk("run_no_valid", AW'(o_rsp_valid), '0);
        chk("run_sort_data", o_sort_data, cap);
      end
    end
    @(posedge i_clk); #1;
    i_sort_done = 1'b0;
    i_rsp_ready = (hold == 0);
`ifdef SORT_ARB_PERF_EN
    perf_m = ex;
`endif
    for (int h = 0; h <= hold; h++) begin
      @(negedge i_clk);
      chk("rsp_valid", AW'(o_rsp_valid), AW'(1));
      chk("rsp_id", AW'(o_rsp_id), AW'(g));
      chk("rsp_data", o_rsp_data, res);
      chk("rsp_timeout", AW'(o_rsp_timeout), AW'(to));
      chk("rsp_start_low", AW'(o_sort_start), '0);
      chk("rsp_no_grant", AW'(o_req_ready), '0);
      chk("rsp_perf", AW'(o_perf_cycles), AW'(perf_m));
      @(posedge i_clk); #1;
      i_rsp_ready = (h + 1 == hold);
    end
    i_rsp_ready = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] arr0;
    logic [NR-1:0] m;
    int g;

    // Reset state
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("rst_busy", AW'(o_busy), '0);
    chk("rst_ready", AW'(o_req_ready), '0);
    chk("rst_start", AW'(o_sort_start), '0);
    chk("rst_rsp_valid", AW'(o_rsp_valid), '0);
    chk("rst_rsp_id", AW'(o_rsp_id), '0);
    chk("rst_rsp_data", o_rsp_data, '0);
    chk("rst_rsp_timeout", AW'(o_rsp_timeout), '0);
    chk("rst_sort_data", o_sort_data, '0);
    chk("rst_perf", AW'(o_perf_cycles), '0);
    @(posedge i_clk); #1;

    // Single known job: {12,1,1,20,0,15,29,1} done after 40 RUN cycles
    arr0[0*SD +: SD] = 8'd12; arr0[1*SD +: SD] = 8'd1;
    arr0[2*SD +: SD] = 8'd1;  arr0[3*SD +: SD] = 8'd20;
    arr0[4*SD +: SD] = 8'd0;  arr0[5*SD +: SD] = 8'd15;
    arr0[6*SD +: SD] = 8'd29; arr0[7*SD +: SD] = 8'd1;
    i_req_data[0 +: AW] = arr0;
    run_job(4'b0001, 40, 0);

    // No requests: stays idle, no grant
    i_req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      chk("noreq_busy", AW'(o_busy), '0);
      chk("noreq_ready", AW'(o_req_ready), '0);
      @(posedge i_clk); #1;
    end

    // Round-robin with all requesters held high
    for (int r = 0; r < NR; r++) i_req_data[r*AW +: AW] = rand_arr();
    for (int j = 0; j < 8; j++) run_job(4'b1111, $urandom_range(1, 20), $urandom_range(0, 2));

    // Back-pressure: response held for 10 cycles
    run_job(4'b0110, 7, 10);

    // Timeout: sorter never finishes
    run_job(4'b1000, 0, 1);
    // Done arriving too late also times out
    run_job(4'b0001, TO + 3, 0);
    // Done and watchdog expiry in the same cycle: done wins
    run_job(4'b0010, TO, 0);
    // Done already high on the first RUN cycle
    run_job(4'b0100, 1, 0);

    // Randomized jobs
    for (int j = 0; j < 12; j++) begin
      m = NR'($urandom_range(1, 15));
      run_job(m, $urandom_range(1, TO + 4), $urandom_range(0, 3));
    end

    // Reset in the middle of RUN drops the job and resets the pointer
    i_req_valid = 4'b0100;
    @(negedge i_clk);
    g = model_grant(4'b0100);
    chk("mid_grant", AW'(o_req_ready), AW'(1) << g);
    @(posedge i_clk); #1;
    i_req_valid = 4'b1111;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_rst_n = 1'b0;
    #1;
    chk("midrst_busy", AW'(o_busy), '0);
    chk("midrst_start", AW'(o_sort_start), '0);
    chk("midrst_rsp_valid", AW'(o_rsp_valid), '0);
    ptr_m = 0;
    perf_m = 0;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    run_job(4'b1111, 5, 0);
    run_job(4'b1111, 3, 0);

    i_req_valid = '0;
    repeat (3) @(posedge i_clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
